trace_buffer: RTL and testbench

- Downstream consumer of the data packer. Captures each packed N-lane vector into an on-chip circular buffer while tracing.
- When tracing stops, drains the captured vectors oldest-first to the host readout path over a valid/ready handshake.
- Configured over the shared configId/configData byte bus, like the other instrumentation stages.

---
 rtl/trace_buffer_pkg.sv | 21 ++
 rtl/trace_buffer_if.sv | 28 ++
 rtl/trace_buffer_mem.sv | 39 +++
 rtl/trace_buffer.sv | 155 +++++++++++++++
 tb/tb_trace_buffer.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_buffer_pkg.sv
// trace_buffer_pkg: shared types and constants for the trace buffer.
// Holds the drain FSM state type, the mode bit encodings and a default
// packed-vector type for the usual 8 x 32-bit packer configuration.
`timescale 1ns/1ps
package trace_buffer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } tb_state_t;

  // Meaning of mode[0]
  localparam logic MODE_CIRCULAR = 1'b0;
  localparam logic MODE_STOP     = 1'b1;

  localparam int DEFAULT_N          = 8;
  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef logic [DEFAULT_N-1:0][DEFAULT_DATA_WIDTH-1:0] tb_vector_t;

endpackage

// File: rtl/trace_buffer_if.sv
// trace_buffer_if: capture and readout data path of the trace buffer.
//   valid_in/vector_in   : packed vector from the packer (master -> slave)
//   rd_ready             : readout sink ready           (master -> slave)
//   vector_out/valid_out/last_out : drained vector       (slave -> master)
`timescale 1ns/1ps
interface trace_buffer_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
) ();

  logic                           valid_in;
  logic [N-1:0][DATA_WIDTH-1:0]   vector_in;
  logic                           rd_ready;
  logic [N-1:0][DATA_WIDTH-1:0]   vector_out;
  logic                           valid_out;
  logic                           last_out;

  modport master (
    output valid_in, vector_in, rd_ready,
    input  vector_out, valid_out, last_out
  );

  modport slave (
    input  valid_in, vector_in, rd_ready,
    output vector_out, valid_out, last_out
  );

endinterface

// File: rtl/trace_buffer_mem.sv
// tb_mem: simple dual-port RAM for the trace buffer, one write port and one
// read port with a registered output, so it maps onto block RAM.
//   clk, rst           : clock, synchronous reset of the read register only
//   we, wr_addr, wr_data : write port
//   re, rd_addr, rd_data : read port; rd_data updates only when re=1
`timescale 1ns/1ps
module tb_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             re,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Holding rd_data when re=0 is what keeps vector_out stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (re) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/trace_buffer.sv
// trace_buffer: captures packed N-lane vectors into a circular buffer while
// tracing=1, then drains them oldest-first over a valid/ready handshake.
//   clk, rst              : clock, synchronous active-high reset
//   tracing               : 1 = capture, 0 = configuration/readout
//   configId, configData  : shared config byte bus (first byte sets mode)
//   rd_start              : drain request, honoured only while tracing=0
//   bus (slave)           : valid_in/vector_in in, rd_ready in,
//                           vector_out/valid_out/last_out out
//   full, count           : occupancy status
`timescale 1ns/1ps
module trace_buffer
  import trace_buffer_pkg::*;
#(
  parameter int         N                  = 8,
  parameter int         DATA_WIDTH         = 32,
  parameter int         TB_SIZE            = 8,
  parameter logic [7:0] PERSONAL_CONFIG_ID = 8'd0,
  parameter logic [7:0] INITIAL_MODE       = 8'd0,
  localparam int        CW                 = $clog2(TB_SIZE + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tracing,
  input  logic [7:0]    configId,
  input  logic [7:0]    configData,
  input  logic          rd_start,
  trace_buffer_if.slave bus,
  output logic          full,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(TB_SIZE);
  localparam int VW = N * DATA_WIDTH;

  tb_state_t     state, state_next;
  logic [AW-1:0] wr_ptr, rd_ptr, rd_addr;
  logic [7:0]    mode, byte_counter;
  logic          valid_q, last_q, rd_en;
  logic [VW-1:0] rd_data;
  logic          start_drain, accept, last_accept, write_en;

  // Only mode[0] has a meaning; the upper bits are reserved.
  logic unused_mode_bits;
  assign unused_mode_bits = ^mode[7:1];

  assign full        = (count == CW'(TB_SIZE));
  assign start_drain = (state == IDLE) && !tracing && rd_start && (count != '0);
  assign accept      = (state == DRAIN) && valid_q && bus.rd_ready;
  assign last_accept = accept && (count == CW'(1));
  assign write_en    = (state == IDLE) && tracing && bus.valid_in &&
                       !(full && (mode[0] == MODE_STOP));

  assign bus.vector_out = rd_data;
  assign bus.valid_out  = valid_q;
  assign bus.last_out   = last_q;

  tb_mem #(.DEPTH(TB_SIZE), .WIDTH(VW)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we      (write_en),
    .wr_addr (wr_ptr),
    .wr_data (bus.vector_in),
    .re      (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_drain) state_next = DRAIN;
      DRAIN:   if (last_accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read-side prefetch: the entry presented next cycle is rd_ptr on entering
  // DRAIN, or rd_ptr+1 once the current head is accepted.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = rd_ptr;
    if (start_drain) begin
      rd_en = 1'b1;
    end else if (accept && !last_accept) begin
      rd_en   = 1'b1;
      rd_addr = rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      mode         <= INITIAL_MODE;
      byte_counter <= '0;
    end else begin
      // A circular write into a full buffer evicts the oldest entry.
      if (write_en) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (full) begin
          rd_ptr <= rd_ptr + AW'(1);
        end else begin
          count <= count + CW'(1);
        end
      end

      if (start_drain) begin
        valid_q <= 1'b1;
        last_q  <= (count == CW'(1));
      end

      // The drain is destructive: the last beat returns the buffer to empty.
      if (accept) begin
        if (last_accept) begin
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          wr_ptr  <= '0;
          rd_ptr  <= '0;
          count   <= '0;
        end else begin
          rd_ptr <= rd_ptr + AW'(1);
          count  <= count - CW'(1);
          last_q <= (count == CW'(2));
        end
      end

      // Only the first byte of a config burst lands in mode. The counter
      // saturates so an endless burst never wraps back to byte zero.
      if ((state == IDLE) && !tracing) begin
        if (configId == PERSONAL_CONFIG_ID) begin
          if (byte_counter == 8'd0) begin
            mode <= configData;
          end
          if (byte_counter != 8'hFF) begin
            byte_counter <= byte_counter + 8'd1;
          end
        end else begin
          byte_counter <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_trace_buffer.sv
// tb_trace_buffer: directed test of trace_buffer against a queue-based
// behavioural model, plus literal expectations on the drained sequences.
`timescale 1ns/1ps
module tb_trace_buffer;

  localparam int         N          = 8;
  localparam int         DATA_WIDTH = 32;
  localparam int         TB_SIZE    = 8;
  localparam logic [7:0] CFG_ID     = 8'd0;
  localparam logic [7:0] INIT_MODE  = 8'd0;
  localparam int         CW         = $clog2(TB_SIZE + 1);
  localparam int         VW         = N * DATA_WIDTH;

  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tracing = 1'b0;
  logic [7:0]    configId = 8'hFF;
  logic [7:0]    configData = 8'h00;
  logic          rd_start = 1'b0;
  logic          full;
  logic [CW-1:0] count;

  int tests_run = 0;
  int tests_failed = 0;
  bit cmp_en = 1'b0;

  trace_buffer_if #(.N(N), .DATA_WIDTH(DATA_WIDTH)) bus ();

  trace_buffer #(
    .N(N), .DATA_WIDTH(DATA_WIDTH), .TB_SIZE(TB_SIZE),
    .PERSONAL_CONFIG_ID(CFG_ID), .INITIAL_MODE(INIT_MODE)
  ) dut (
    .clk(clk), .rst(rst), .tracing(tracing),
    .configId(configId), .configData(configData), .rd_start(rd_start),
    .bus(bus), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  // Model: the buffer is a queue of vectors, oldest at the front.
  vec_t       m_q[$];
  vec_t       drained_q[$];
  bit         m_drain = 1'b0;
  logic [7:0] m_mode = INIT_MODE;
  bit         m_cfg_seen = 1'b0;

  function automatic vec_t mkvec(input int v);
    vec_t r;
    for (int l = 0; l < N; l++) r[l] = DATA_WIDTH'(v) | (DATA_WIDTH'(l) << 16);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [VW-1:0] actual,
                             input logic [VW-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Model update on each rising edge, from the same inputs the DUT sees.
  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_drain    = 1'b0;
      m_mode     = INIT_MODE;
      m_cfg_seen = 1'b0;
    end else if (m_drain) begin
      if (bus.rd_ready) begin
        drained_q.push_back(bus.vector_out);
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_drain = 1'b0;
      end
    end else begin
      if (tracing && bus.valid_in) begin
        if (m_q.size() < TB_SIZE) begin
          m_q.push_back(bus.vector_in);
        end else if (m_mode[0] == 1'b0) begin
          void'(m_q.pop_front());
          m_q.push_back(bus.vector_in);
        end
      end
      if (!tracing) begin
        if (configId == CFG_ID) begin
          if (!m_cfg_seen) m_mode = configData;
          m_cfg_seen = 1'b1;
        end else begin
          m_cfg_seen = 1'b0;
        end
        if (rd_start && m_q.size() > 0) m_drain = 1'b1;
      end
    end
  end

  // Compare process: every cycle, just after the edge.
  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      checkOutput("count", VW'(count), VW'(m_q.size()));
      checkOutput("full", VW'(full), VW'(m_q.size() == TB_SIZE));
      checkOutput("valid_out", VW'(bus.valid_out), VW'(m_drain));
      if (m_drain) begin
        checkOutput("vector_out", bus.vector_out, m_q[0]);
        checkOutput("last_out", VW'(bus.last_out), VW'(m_q.size() == 1));
      end else begin
        checkOutput("last_out_idle", VW'(bus.last_out), VW'(0));
      end
    end
  end

  // One cycle: drive at the falling edge, return after the rising edge settles.
  task automatic applyStimulus(input logic t, input logic v, input int val,
                               input logic start, input logic ready);
    @(negedge clk);
    tracing      = t;
    bus.valid_in = v;
    bus.vector_in = mkvec(val);
    rd_start     = start;
    bus.rd_ready = ready;
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drained_q.delete();
  endtask

  task automatic configMode(input logic [7:0] b);
    @(negedge clk);
    configId   = CFG_ID;
    configData = b;
    applyStimulus(0, 0, 0, 0, 0);
    configId = 8'hFF;
    applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic writeRange(input int first, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 1, first + i, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic finishDrain(input int max_cycles);
    int n = 0;
    while (m_drain && n < max_cycles) begin
      applyStimulus(0, 0, 0, 0, 1);
      n++;
    end
    if (m_drain) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain_timeout: still draining after %0d cycles, required done", n);
    end
    applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic drainAll();
    drained_q.delete();
    applyStimulus(0, 0, 0, 1, 1);
    finishDrain(40);
  endtask

  task automatic checkDrained(input string tag, input int first, input int n);
    checkOutput({tag, "_len"}, VW'(drained_q.size()), VW'(n));
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s_beat%0d", tag, i), drained_q[i], mkvec(first + i));
  endtask

  initial begin
    vec_t snap_v;
    logic snap_l;
    bus.valid_in = 1'b0;
    bus.vector_in = '0;
    bus.rd_ready = 1'b0;
    doReset();
    cmp_en = 1'b1;
    checkOutput("reset_count", VW'(count), VW'(0));
    checkOutput("reset_valid", VW'(bus.valid_out), VW'(0));
    checkOutput("reset_vector", bus.vector_out, VW'(0));

    // 1. Fill and drain with explicit beat timing.
    writeRange(1, 3);
    checkOutput("t1_count", VW'(count), VW'(3));
    drained_q.delete();
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("t1_first_valid", VW'(bus.valid_out), VW'(1));
    checkOutput("t1_beat1", bus.vector_out, mkvec(1));
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t1_beat2", bus.vector_out, mkvec(2));
    checkOutput("t1_last2", VW'(bus.last_out), VW'(0));
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t1_beat3", bus.vector_out, mkvec(3));
    checkOutput("t1_last3", VW'(bus.last_out), VW'(1));
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t1_done_valid", VW'(bus.valid_out), VW'(0));
    checkOutput("t1_done_count", VW'(count), VW'(0));

    // 2. Circular overwrite.
    doReset();
    writeRange(0, 10);
    checkOutput("t2_full", VW'(full), VW'(1));
    checkOutput("t2_count", VW'(count), VW'(8));
    drainAll();
    checkDrained("t2", 2, 8);

    // 3. Stop-when-full.
    doReset();
    configMode(8'h01);
    writeRange(0, 10);
    checkOutput("t3_count", VW'(count), VW'(8));
    drainAll();
    checkDrained("t3", 0, 8);

    // 4. Backpressure on beat 2.
    doReset();
    writeRange(10, 5);
    drained_q.delete();
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 1);
    snap_v = bus.vector_out;
    snap_l = bus.last_out;
    checkOutput("t4_beat2", snap_v, mkvec(11));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput($sformatf("t4_hold_vec%0d", i), bus.vector_out, snap_v);
      checkOutput($sformatf("t4_hold_last%0d", i), VW'(bus.last_out), VW'(snap_l));
      checkOutput($sformatf("t4_hold_valid%0d", i), VW'(bus.valid_out), VW'(1));
    end
    finishDrain(40);
    checkDrained("t4", 10, 5);

    // 5. Ignored requests; tracing, valid_in and config during DRAIN.
    doReset();
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t5_empty_start", VW'(bus.valid_out), VW'(0));
    writeRange(20, 2);
    drained_q.delete();
    applyStimulus(0, 0, 0, 1, 0);
    @(negedge clk);
    configId = CFG_ID;
    configData = 8'h01;
    applyStimulus(1, 1, 99, 0, 0);
    applyStimulus(1, 1, 98, 0, 0);
    configId = 8'hFF;
    finishDrain(40);
    checkOutput("t5_count_after", VW'(count), VW'(0));
    checkDrained("t5", 20, 2);
    writeRange(50, 9);
    drainAll();
    checkDrained("t5_circ", 51, 8);

    // 6. Reset mid-drain restores the initial mode.
    doReset();
    configMode(8'h01);
    writeRange(30, 5);
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 1);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t6_valid", VW'(bus.valid_out), VW'(0));
    checkOutput("t6_count", VW'(count), VW'(0));
    @(negedge clk);
    rst = 1'b0;
    writeRange(40, 1);
    drainAll();
    checkDrained("t6_single", 40, 1);
    writeRange(40, 9);
    drainAll();
    checkDrained("t6_circ", 41, 8);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
